// File: rtl/snn_ff_pkg.sv
// Shared definitions for the presynaptic spike-count scheduling slice:
// scheduler state encoding, default widths and a constant log2 helper.
package snn_ff_pkg;

  localparam int DEF_PRE_NEUR_ADDR_WIDTH      = 8;
  localparam int DEF_PRE_NEUR_SPIKE_CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    SCHED_IDLE,
    SCHED_RD,
    SCHED_WR,
    SCHED_STEP,
    SCHED_REF
  } sched_state_t;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pre_neuron.sv
// Presynaptic spike-count update unit. A spike event merges the one-hot bit
// of the current time step and the step index into the stored word; a time
// reference event clears the word; otherwise the word passes through as is.
module pre_neuron
  import snn_ff_pkg::*;
#(
  parameter int SPIKE_CNT_WIDTH = DEF_PRE_NEUR_SPIKE_CNT_WIDTH,
  parameter int TS_WIDTH        = 3
) (
  input  logic                       neuron_event,
  input  logic                       neuron_event_pulse,
  input  logic                       time_ref_event,
  input  logic [TS_WIDTH-1:0]        current_time_step,
  input  logic [SPIKE_CNT_WIDTH-1:0] spike_cnt_in,
  output logic [SPIKE_CNT_WIDTH-1:0] spike_cnt_out
);

  logic [SPIKE_CNT_WIDTH-1:0] step_onehot;
  logic [SPIKE_CNT_WIDTH-1:0] step_index;

  assign step_onehot = SPIKE_CNT_WIDTH'(1) << current_time_step;
  assign step_index  = SPIKE_CNT_WIDTH'(current_time_step);

  // Reference clear wins over a spike so the sweep always writes zero.
  always_comb begin
    spike_cnt_out = spike_cnt_in;
    if (time_ref_event) begin
      spike_cnt_out = '0;
    end else if (neuron_event && neuron_event_pulse) begin
      spike_cnt_out = spike_cnt_in | step_onehot | step_index;
    end
  end

endmodule

// File: rtl/pre_neuron_sched.sv
// Scheduler for read-modify-write updates of the presynaptic spike-count
// SRAM. Accepts spike events and end-of-step pulses, owns the time-step
// counter and runs a clearing sweep of the whole SRAM once per window.
module pre_neuron_sched
  import snn_ff_pkg::*;
#(
  parameter int PRE_NEUR_NUM             = 256,
  parameter int PRE_NEUR_ADDR_WIDTH      = DEF_PRE_NEUR_ADDR_WIDTH,
  parameter int PRE_NEUR_SPIKE_CNT_WIDTH = DEF_PRE_NEUR_SPIKE_CNT_WIDTH,
  parameter int TIME_STEP                = 8,
  localparam int TS_WIDTH                = clog2(TIME_STEP)
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic                                spike_valid,
  input  logic [PRE_NEUR_ADDR_WIDTH-1:0]      spike_addr,
  output logic                                spike_ready,
  input  logic                                step_done,
  output logic                                sram_cs,
  output logic                                sram_we,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0]      sram_addr,
  output logic [PRE_NEUR_SPIKE_CNT_WIDTH-1:0] sram_wdata,
  input  logic [PRE_NEUR_SPIKE_CNT_WIDTH-1:0] sram_rdata,
  output logic [TS_WIDTH-1:0]                 current_time_step,
  output logic                                ref_busy,
  output logic                                ref_done,
  output logic                                step_overrun
);

  localparam logic [PRE_NEUR_ADDR_WIDTH:0]   NUM_EXT   = (PRE_NEUR_ADDR_WIDTH + 1)'(PRE_NEUR_NUM);
  localparam logic [PRE_NEUR_ADDR_WIDTH-1:0] LAST_ADDR = PRE_NEUR_ADDR_WIDTH'(PRE_NEUR_NUM - 1);
  localparam logic [TS_WIDTH-1:0]            LAST_STEP = TS_WIDTH'(TIME_STEP - 1);

  sched_state_t state;
  sched_state_t next_state;

  logic [PRE_NEUR_ADDR_WIDTH-1:0]      spike_addr_q;
  logic [PRE_NEUR_ADDR_WIDTH-1:0]      sweep_addr;
  logic [TS_WIDTH-1:0]                 ts_cnt;
  logic                                step_pending;
  logic                                ref_done_q;
  logic                                overrun_q;
  logic                                ready_int;
  logic                                addr_in_range;
  logic                                sweep_last;
  logic                                unit_event;
  logic                                unit_ref;
  logic [PRE_NEUR_SPIKE_CNT_WIDTH-1:0] unit_out;

  assign addr_in_range     = {1'b0, spike_addr} < NUM_EXT;
  assign sweep_last        = (sweep_addr == LAST_ADDR);
  assign current_time_step = ts_cnt;
  assign ref_done          = ref_done_q;
  assign step_overrun      = overrun_q;
  // Gated by the reset pin so the output is low for as long as reset is held.
  assign spike_ready       = ready_int & RST_N;

  pre_neuron #(
    .SPIKE_CNT_WIDTH (PRE_NEUR_SPIKE_CNT_WIDTH),
    .TS_WIDTH        (TS_WIDTH)
  ) u_update (
    .neuron_event       (unit_event),
    .neuron_event_pulse (unit_event),
    .time_ref_event     (unit_ref),
    .current_time_step  (ts_cnt),
    .spike_cnt_in       (sram_rdata),
    .spike_cnt_out      (unit_out)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= SCHED_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and SRAM/handshake decode; a pending step beats a new spike.
  always_comb begin
    next_state = state;
    ready_int  = 1'b0;
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    unit_event = 1'b0;
    unit_ref   = 1'b0;
    ref_busy   = 1'b0;
    case (state)
      SCHED_IDLE: begin
        ready_int = !step_pending;
        if (step_pending) begin
          next_state = SCHED_STEP;
        end else if (spike_valid && addr_in_range) begin
          next_state = SCHED_RD;
        end
      end
      SCHED_RD: begin
        sram_cs    = 1'b1;
        sram_addr  = spike_addr_q;
        next_state = SCHED_WR;
      end
      SCHED_WR: begin
        sram_cs    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = spike_addr_q;
        unit_event = 1'b1;
        sram_wdata = unit_out;
        next_state = SCHED_IDLE;
      end
      SCHED_STEP: begin
        next_state = (ts_cnt == LAST_STEP) ? SCHED_REF : SCHED_IDLE;
      end
      SCHED_REF: begin
        ref_busy   = 1'b1;
        sram_cs    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = sweep_addr;
        unit_ref   = 1'b1;
        sram_wdata = unit_out;
        if (sweep_last) begin
          next_state = SCHED_IDLE;
        end
      end
      default: begin
        next_state = SCHED_IDLE;
      end
    endcase
  end

  // Address capture, step counter, sweep pointer and step bookkeeping flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      spike_addr_q <= '0;
      sweep_addr   <= '0;
      ts_cnt       <= '0;
      step_pending <= 1'b0;
      ref_done_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if ((state == SCHED_IDLE) && spike_valid && ready_int && addr_in_range) begin
        spike_addr_q <= spike_addr;
      end
      if (state == SCHED_STEP) begin
        ts_cnt <= (ts_cnt == LAST_STEP) ? '0 : ts_cnt + TS_WIDTH'(1);
      end
      if (state == SCHED_REF) begin
        sweep_addr <= sweep_last ? '0 : sweep_addr + PRE_NEUR_ADDR_WIDTH'(1);
      end
      ref_done_q <= (state == SCHED_REF) && sweep_last;
      if (state == SCHED_STEP) begin
        step_pending <= 1'b0;
      end
      if (step_done) begin
        if (step_pending) begin
          overrun_q <= 1'b1;
        end else begin
          step_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pre_neuron_sched.sv
// Directed bench for pre_neuron_sched: behavioural SRAM, write scoreboard
// and cycle-level checks of handshake, step counter and clearing sweep.
module tb_pre_neuron_sched;

  localparam int TS = 8;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       CLK;
  logic       RST_N;
  logic       spike_valid;
  logic [7:0] spike_addr;
  logic       spike_ready;
  logic       step_done;
  logic       sram_cs;
  logic       sram_we;
  logic [7:0] sram_addr;
  logic [7:0] sram_wdata;
  logic [7:0] sram_rdata;
  logic [2:0] current_time_step;
  logic       ref_busy;
  logic       ref_done;
  logic       step_overrun;

  logic       spike_valid_9;
  logic [8:0] spike_addr_9;
  logic       spike_ready_9;
  logic       step_done_9;
  logic       sram_cs_9;
  logic       sram_we_9;
  logic [8:0] sram_addr_9;
  logic [7:0] sram_wdata_9;
  logic [2:0] current_time_step_9;
  logic       ref_busy_9;
  logic       ref_done_9;
  logic       step_overrun_9;

  logic [7:0] mem [256];
  wr_t        exp_q[$];
  int         tests_run;
  int         tests_failed;
  int         ts_model;

  pre_neuron_sched u_dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .spike_valid       (spike_valid),
    .spike_addr        (spike_addr),
    .spike_ready       (spike_ready),
    .step_done         (step_done),
    .sram_cs           (sram_cs),
    .sram_we           (sram_we),
    .sram_addr         (sram_addr),
    .sram_wdata        (sram_wdata),
    .sram_rdata        (sram_rdata),
    .current_time_step (current_time_step),
    .ref_busy          (ref_busy),
    .ref_done          (ref_done),
    .step_overrun      (step_overrun)
  );

  pre_neuron_sched #(
    .PRE_NEUR_NUM        (256),
    .PRE_NEUR_ADDR_WIDTH (9)
  ) u_dut9 (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .spike_valid       (spike_valid_9),
    .spike_addr        (spike_addr_9),
    .spike_ready       (spike_ready_9),
    .step_done         (step_done_9),
    .sram_cs           (sram_cs_9),
    .sram_we           (sram_we_9),
    .sram_addr         (sram_addr_9),
    .sram_wdata        (sram_wdata_9),
    .sram_rdata        (8'h00),
    .current_time_step (current_time_step_9),
    .ref_busy          (ref_busy_9),
    .ref_done          (ref_done_9),
    .step_overrun      (step_overrun_9)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural single-port SRAM with one-cycle read latency.
  always @(posedge CLK) begin
    if (sram_cs) begin
      if (sram_we) begin
        mem[sram_addr] <= sram_wdata;
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  // Expected word after a spike lands in step ts on a word holding old.
  function automatic logic [7:0] model(input logic [7:0] old, input int ts);
    return old | (8'd1 << ts) | 8'(ts);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Every SRAM write must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    wr_t got;
    if (sram_cs && sram_we) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", {16'h0, sram_addr, sram_wdata}, 32'hFFFF_FFFF);
      end else begin
        got = exp_q.pop_front();
        checkOutput("write_addr", 32'(sram_addr), 32'(got.addr));
        checkOutput("write_data", 32'(sram_wdata), 32'(got.data));
      end
    end
  end

  // Offers one spike, books its expected write and waits for acceptance.
  task automatic applyStimulus(input logic [7:0] addr);
    logic ok;
    ok = 1'b0;
    exp_q.push_back('{addr: addr, data: model(mem[addr], ts_model)});
    @(posedge CLK);
    #1 spike_valid = 1'b1;
    spike_addr = addr;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (spike_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("spike_accept", 32'(ok), 32'd1);
    @(posedge CLK);
    #1 spike_valid = 1'b0;
  endtask

  task automatic pulseStep(input int gap);
    @(posedge CLK);
    #1 step_done = 1'b1;
    @(posedge CLK);
    #1 step_done = 1'b0;
    ts_model = (ts_model + 1) % TS;
    repeat (gap) @(posedge CLK);
  endtask

  task automatic doReset();
    @(posedge CLK);
    #1 RST_N = 1'b0;
    @(posedge CLK);
    #1 RST_N = 1'b1;
    ts_model = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busy_cycles;
    int done_cycles;
    int last_busy_iter;
    int done_iter;
    int ts_in_sweep;
    logic found;

    tests_run     = 0;
    tests_failed  = 0;
    ts_model      = 0;
    RST_N         = 1'b0;
    spike_valid   = 1'b0;
    spike_addr    = '0;
    step_done     = 1'b0;
    spike_valid_9 = 1'b0;
    spike_addr_9  = '0;
    step_done_9   = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state.
    @(negedge CLK);
    checkOutput("reset_outputs", 32'({spike_ready, sram_cs, sram_we, sram_addr, sram_wdata,
                current_time_step, ref_busy, ref_done, step_overrun}), 32'd0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    checkOutput("ready_after_reset", 32'(spike_ready), 32'd1);
    checkOutput("counter_after_reset", 32'(current_time_step), 32'd0);

    // Advance to step 2.
    pulseStep(8);
    @(negedge CLK);
    checkOutput("counter_step1", 32'(current_time_step), 32'(ts_model));
    pulseStep(8);
    @(negedge CLK);
    checkOutput("counter_step2", 32'(current_time_step), 32'(ts_model));

    // Spike at step 2 with step_done arriving during its write cycle.
    applyStimulus(8'd7);
    @(posedge CLK);
    #1 step_done = 1'b1;
    @(negedge CLK);
    checkOutput("wr_step2_data", 32'(sram_wdata), 32'h06);
    @(posedge CLK);
    #1 step_done = 1'b0;
    ts_model = 3;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    checkOutput("counter_after_wr_step", 32'(current_time_step), 32'd3);

    // Spike at step 3, cycle by cycle.
    applyStimulus(8'd5);
    @(negedge CLK);
    checkOutput("rd_cycle", 32'({sram_cs, sram_we, spike_ready}), 32'b100);
    checkOutput("rd_addr", 32'(sram_addr), 32'd5);
    @(negedge CLK);
    checkOutput("wr_cycle", 32'({sram_cs, sram_we, spike_ready}), 32'b110);
    checkOutput("wr_addr", 32'(sram_addr), 32'd5);
    checkOutput("wr_step3_data", 32'(sram_wdata), 32'h0B);
    @(negedge CLK);
    checkOutput("ready_returns", 32'(spike_ready), 32'd1);
    checkOutput("no_access_idle", 32'(sram_cs), 32'd0);

    // Full window of 8 steps from 0, then the clearing sweep.
    doReset();
    for (int i = 0; i < 7; i++) begin
      pulseStep(8);
      @(negedge CLK);
      checkOutput("counter_window", 32'(current_time_step), 32'(ts_model));
    end
    for (int a = 0; a < 256; a++) exp_q.push_back('{addr: 8'(a), data: 8'h00});
    pulseStep(0);
    busy_cycles    = 0;
    done_cycles    = 0;
    last_busy_iter = -1;
    done_iter      = -1;
    ts_in_sweep    = -1;
    for (int it = 0; it < 400; it++) begin
      @(negedge CLK);
      if (ref_busy) begin
        busy_cycles++;
        last_busy_iter = it;
        if (busy_cycles == 1) ts_in_sweep = int'(current_time_step);
      end
      if (ref_done) begin
        done_cycles++;
        done_iter = it;
      end
      step_done = (it == 20) || (it == 25);
      if ((busy_cycles > 0) && !ref_busy && (it >= last_busy_iter + 6)) break;
    end
    step_done = 1'b0;
    ts_model = 1;
    checkOutput("ref_busy_cycles", 32'(busy_cycles), 32'd256);
    checkOutput("ref_done_count", 32'(done_cycles), 32'd1);
    checkOutput("ref_done_timing", 32'(done_iter), 32'(last_busy_iter + 1));
    checkOutput("counter_wrapped", 32'(ts_in_sweep), 32'd0);
    checkOutput("sweep_writes_done", 32'(exp_q.size()), 32'd0);
    checkOutput("overrun_set", 32'(step_overrun), 32'd1);
    checkOutput("counter_one_step", 32'(current_time_step), 32'd1);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    checkOutput("overrun_sticky", 32'(step_overrun), 32'd1);
    checkOutput("counter_stable", 32'(current_time_step), 32'd1);

    // Reset in the middle of a sweep, with address 100 on the bus.
    doReset();
    for (int i = 0; i < 7; i++) pulseStep(3);
    for (int a = 0; a < 100; a++) exp_q.push_back('{addr: 8'(a), data: 8'h00});
    pulseStep(0);
    found = 1'b0;
    for (int it = 0; it < 400; it++) begin
      @(negedge CLK);
      if (ref_busy && (sram_addr == 8'd99)) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("sweep_reached_99", 32'(found), 32'd1);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("midsweep_reset_outputs", 32'({spike_ready, sram_cs, sram_we, sram_addr, sram_wdata,
                current_time_step, ref_busy, ref_done, step_overrun}), 32'd0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    ts_model = 0;
    @(negedge CLK);
    checkOutput("post_reset_idle", 32'({spike_ready, ref_busy, sram_cs}), 32'b100);
    checkOutput("post_reset_counter", 32'(current_time_step), 32'd0);
    checkOutput("partial_sweep_writes", 32'(exp_q.size()), 32'd0);

    // Out-of-range address on the 9-bit instance: accepted, no SRAM access.
    @(posedge CLK);
    #1 spike_valid_9 = 1'b1;
    spike_addr_9 = 9'd300;
    @(negedge CLK);
    checkOutput("oor_ready", 32'(spike_ready_9), 32'd1);
    @(posedge CLK);
    #1 spike_valid_9 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("oor_no_access", 32'({sram_cs_9, spike_ready_9}), 32'b01);
    end
    @(posedge CLK);
    #1 spike_valid_9 = 1'b1;
    spike_addr_9 = 9'd255;
    @(posedge CLK);
    #1 spike_valid_9 = 1'b0;
    @(negedge CLK);
    checkOutput("inrange_read_9", 32'({sram_cs_9, sram_we_9, sram_addr_9}), 32'({2'b10, 9'd255}));

    repeat (3) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
